// File: rtl/otter_alu_defs_pkg.sv
// Shared OTTER ALU definitions: operand width, alu_fun codes and the
// illegal-code set used by the optional checker (ALU_ILLEGAL_CHK_EN).
package otter_alu_defs;

    localparam int WIDTH = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SLL  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_SUB  = 4'd8;
    localparam logic [3:0] ALU_LUI  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd13;

    // Codes with no defined operation: 10, 11, 12, 14, 15
    function automatic logic is_illegal(input logic [3:0] fun);
        return (fun == 4'd10) || (fun == 4'd11) || (fun == 4'd12) ||
               (fun == 4'd14) || (fun == 4'd15);
    endfunction

endpackage

// File: rtl/riscv_alu.sv
// OTTER ALU: purely combinational, shift amount taken from srcB[4:0].
module riscv_alu
    import otter_alu_defs::*;
(
    input  logic [3:0]       alu_fun,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic [WIDTH-1:0] result
);

    // Operation select; undefined codes produce 0
    always_comb begin
        result = '0;
        case (alu_fun)
            ALU_ADD:  result = srcA + srcB;
            ALU_SLL:  result = srcA << srcB[4:0];
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, $signed(srcA) < $signed(srcB)};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, srcA < srcB};
            ALU_XOR:  result = srcA ^ srcB;
            ALU_SRL:  result = srcA >> srcB[4:0];
            ALU_OR:   result = srcA | srcB;
            ALU_AND:  result = srcA & srcB;
            ALU_SUB:  result = srcA - srcB;
            ALU_LUI:  result = srcA;
            ALU_SRA:  result = $unsigned($signed(srcA) >>> srcB[4:0]);
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Two-port round-robin arbiter time-sharing a single riscv_alu.
// Each port owns a registered result slot with valid/ready backpressure;
// a slot may be refilled in the same cycle it drains.
// Optional: ALU_ILLEGAL_CHK_EN adds rsp0_err/rsp1_err and zeroes the
// result of undefined alu_fun codes.
module alu_share_arb
    import otter_alu_defs::*;
#(
    parameter bit PRIO_INIT = 1'b0,
    parameter int WIDTH     = otter_alu_defs::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_fun,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
`ifdef ALU_ILLEGAL_CHK_EN
    output logic             rsp0_err,
    output logic             rsp1_err,
`endif
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_fun,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result
);

    logic                  last_grant;
    logic [1:0]            elig, grant, rsp_valid_q, rsp_rdy;
    logic [1:0][WIDTH-1:0] rsp_result_q;
    logic [3:0]            alu_fun;
    logic [WIDTH-1:0]      alu_a, alu_b, alu_y, slot_d;
    logic                  slot_err;

    assign rsp_rdy = {rsp1_ready, rsp0_ready};

    // A port competes only when its slot is empty or being drained this cycle
    assign elig = {req1_valid, req0_valid} & (~rsp_valid_q | rsp_rdy) & {2{~rst}};

    // Round-robin: on contention, the port not granted last time wins
    always_comb begin
        grant = 2'b00;
        case (elig)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Granted port drives the ALU; idle cycles present all-zero operands
    always_comb begin
        alu_fun = '0;
        alu_a   = '0;
        alu_b   = '0;
        if (grant[0]) begin
            alu_fun = req0_fun;
            alu_a   = req0_a;
            alu_b   = req0_b;
        end else if (grant[1]) begin
            alu_fun = req1_fun;
            alu_a   = req1_a;
            alu_b   = req1_b;
        end
    end

    riscv_alu u_alu (
        .alu_fun (alu_fun),
        .srcA    (alu_a),
        .srcB    (alu_b),
        .result  (alu_y)
    );

`ifdef ALU_ILLEGAL_CHK_EN
    assign slot_err = is_illegal(alu_fun);
    assign slot_d   = slot_err ? '0 : alu_y;
`else
    assign slot_err = 1'b0;
    assign slot_d   = alu_y;
`endif

    // Grant history; initialised so PRIO_INIT wins the first tie
    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= ~PRIO_INIT;
        else if (|grant)
            last_grant <= grant[1];
    end

    // Result slots: load on grant, else clear valid on consume, else hold
    logic [1:0] rsp_err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (grant[p]) begin
                    rsp_valid_q[p]  <= 1'b1;
                    rsp_result_q[p] <= slot_d;
                    rsp_err_q[p]    <= slot_err;
                end else if (rsp_rdy[p] && rsp_valid_q[p]) begin
                    rsp_valid_q[p]  <= 1'b0;
                end
            end
        end
    end

    assign rsp0_valid  = rsp_valid_q[0];
    assign rsp1_valid  = rsp_valid_q[1];
    assign rsp0_result = rsp_result_q[0];
    assign rsp1_result = rsp_result_q[1];
`ifdef ALU_ILLEGAL_CHK_EN
    assign rsp0_err    = rsp_err_q[0];
    assign rsp1_err    = rsp_err_q[1];
`else
    logic unused_err;
    assign unused_err  = ^rsp_err_q;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed arbitration/backpressure/
// reset cases plus a randomized phase, all results checked by a scoreboard.
module tb_alu_share_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 0, req1_valid = 0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_fun = 0, req1_fun = 0;
    logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1, rsp1_ready = 1;
    logic [31:0] rsp0_result, rsp1_result;
`ifdef ALU_ILLEGAL_CHK_EN
    logic        rsp0_err, rsp1_err;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        err;
        logic [31:0] res;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    alu_share_arb #(.PRIO_INIT(1'b0)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_fun    (req0_fun),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp0_result (rsp0_result),
`ifdef ALU_ILLEGAL_CHK_EN
        .rsp0_err    (rsp0_err),
        .rsp1_err    (rsp1_err),
`endif
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_fun    (req1_fun),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp1_result (rsp1_result)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference ALU
    function automatic exp_t model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.err = 1'b0;
        case (f)
            4'd0:    e.res = a + b;
            4'd1:    e.res = a << b[4:0];
            4'd2:    e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3:    e.res = (a < b) ? 32'd1 : 32'd0;
            4'd4:    e.res = a ^ b;
            4'd5:    e.res = a >> b[4:0];
            4'd6:    e.res = a | b;
            4'd7:    e.res = a & b;
            4'd8:    e.res = a - b;
            4'd9:    e.res = a;
            4'd13:   e.res = $unsigned($signed(a) >>> b[4:0]);
            default: begin e.res = 32'd0; e.err = 1'b1; end
        endcase
        return e;
    endfunction

    // Scoreboard: compare consumed responses, then record this cycle's accepts
    always @(negedge clk) begin
        exp_t e;
        if (rsp0_valid === 1'b1 && rsp0_ready) begin
            if (q0.size() == 0) chk("rsp0_spurious", 1, 0);
            else begin
                e = q0.pop_front();
                chk("sb_rsp0_result", rsp0_result, e.res);
`ifdef ALU_ILLEGAL_CHK_EN
                chk("sb_rsp0_err", rsp0_err, e.err);
`endif
            end
        end
        if (rsp1_valid === 1'b1 && rsp1_ready) begin
            if (q1.size() == 0) chk("rsp1_spurious", 1, 0);
            else begin
                e = q1.pop_front();
                chk("sb_rsp1_result", rsp1_result, e.res);
`ifdef ALU_ILLEGAL_CHK_EN
                chk("sb_rsp1_err", rsp1_err, e.err);
`endif
            end
        end
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (req0_valid && req0_ready === 1'b1) q0.push_back(model(req0_fun, req0_a, req0_b));
            if (req1_valid && req1_ready === 1'b1) q1.push_back(model(req1_fun, req1_a, req1_b));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rand_fun();
        logic [3:0] legal [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 13};
`ifdef ALU_ILLEGAL_CHK_EN
        return 4'($urandom_range(15));
`else
        return legal[$urandom_range(10)];
`endif
    endfunction

    // One isolated port-0 op: accepted same cycle, result next cycle
    task automatic one_op(input string tag, input logic [3:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        cyc();
        req0_valid = 1; req0_fun = f; req0_a = a; req0_b = b;
        #1 chk({tag, "_ready"}, req0_ready, 1);
        cyc();
        req0_valid = 0;
        chk({tag, "_valid"}, rsp0_valid, 1);
        chk({tag, "_result"}, rsp0_result, exp);
    endtask

    initial begin
        // Reset: ready must stay low even with a valid request
        req0_valid = 1;
        cyc();
        cyc();
        chk("rst_ready0", req0_ready, 0);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_rsp0_result", rsp0_result, 0);
        chk("rst_rsp1_result", rsp1_result, 0);
        req0_valid = 0;
        rst = 0;

        one_op("add", 4'd0, 32'd25, 32'd26, 32'd51);

        // Contention right after reset: port 0 first, then alternate
        cyc(); rst = 1;
        cyc(); rst = 0;
        req0_valid = 1; req0_fun = 4'd8;  req0_a = 32'hFFFFFFFF; req0_b = 32'd1;
        req1_valid = 1; req1_fun = 4'd13; req1_a = 32'h8000FF00; req1_b = 32'h85;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("cont_ready0", req0_ready, (k % 2 == 0));
            chk("cont_ready1", req1_ready, (k % 2 == 1));
            if (k == 1) chk("cont_sub", rsp0_result, 32'hFFFFFFFE);
            if (k == 2) chk("cont_sra", rsp1_result, 32'hFC0007F8);
            cyc();
        end
        req0_valid = 0; req1_valid = 0;

        one_op("slt",  4'd2, 32'h8000FF00, 32'd5,  32'd1);
        one_op("sltu", 4'd3, 32'h8000FF00, 32'd5,  32'd0);
        one_op("sll",  4'd1, 32'h0000FF00, 32'h85, 32'h001FE000);
        one_op("lui",  4'd9, 32'h0000FF00, 32'd7,  32'h0000FF00);
`ifdef ALU_ILLEGAL_CHK_EN
        one_op("ill15", 4'd15, 32'h1234, 32'h5678, 32'd0);
        chk("ill15_err", rsp0_err, 1);
        one_op("lui_err", 4'd9, 32'h0000FF00, 32'd0, 32'h0000FF00);
        chk("lui_err", rsp0_err, 0);
`endif

        // Backpressure: stalled port 0 holds its result, port 1 runs freely
        cyc(); cyc();
        rsp0_ready = 0;
        req0_valid = 1; req0_fun = 4'd0; req0_a = 32'd1; req0_b = 32'd2;
        #1 chk("bp_fill_ready0", req0_ready, 1);
        cyc();
        req0_fun = 4'd4; req0_a = 32'hF0; req0_b = 32'h0F;
        for (int k = 0; k < 4; k++) begin
            req1_valid = 1; req1_fun = rand_fun(); req1_a = $urandom; req1_b = $urandom;
            #1;
            chk("bp_ready0", req0_ready, 0);
            chk("bp_ready1", req1_ready, 1);
            chk("bp_valid0", rsp0_valid, 1);
            chk("bp_hold0", rsp0_result, 32'd3);
            cyc();
        end
        rsp0_ready = 1;
        #1 chk("bp_refill_ready0", req0_ready, 1);
        cyc();
        req0_valid = 0; req1_valid = 0;
        chk("bp_refill_result", rsp0_result, 32'hFF);

        // Randomized traffic with random backpressure
        for (int k = 0; k < 300; k++) begin
            cyc();
            req0_valid = 1'($urandom); req0_fun = rand_fun(); req0_a = $urandom; req0_b = $urandom;
            req1_valid = 1'($urandom); req1_fun = rand_fun(); req1_a = $urandom; req1_b = $urandom;
            rsp0_ready = ($urandom_range(3) != 0);
            rsp1_ready = ($urandom_range(3) != 0);
        end
        cyc();
        req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        cyc(); cyc();
        chk("rand_drain0", q0.size(), 0);
        chk("rand_drain1", q1.size(), 0);

        // Reset mid-stream with a stalled port-1 result
        rsp1_ready = 0;
        req1_valid = 1; req1_fun = 4'd6; req1_a = 32'h10; req1_b = 32'h01;
        cyc();
        req1_valid = 0;
        chk("mid_pre_valid1", rsp1_valid, 1);
        rst = 1;
        cyc();
        chk("mid_rsp0_valid", rsp0_valid, 0);
        chk("mid_rsp1_valid", rsp1_valid, 0);
        chk("mid_rsp0_result", rsp0_result, 0);
        chk("mid_rsp1_result", rsp1_result, 0);
        rst = 0; rsp1_ready = 1;
        req0_valid = 1; req0_fun = 4'd7; req0_a = 32'hFF; req0_b = 32'h0F;
        req1_valid = 1; req1_fun = 4'd5; req1_a = 32'h100; req1_b = 32'h4;
        #1;
        chk("mid_prio_ready0", req0_ready, 1);
        chk("mid_prio_ready1", req1_ready, 0);
        cyc();
        req0_valid = 0;
        #1 chk("mid_next_ready1", req1_ready, 1);
        cyc();
        req1_valid = 0;
        cyc(); cyc();
        chk("final_q0", q0.size(), 0);
        chk("final_q1", q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
